// File: rtl/register_file_param.sv
// register_file_param
// -------------------
// Parametrised two-read / one-write register file that sits between decode
// (read addresses) and writeback (write port).
//
// After reset a clear sequencer walks every entry and writes zero, one entry
// per clock. Reads return zero and writes are ignored until the walk
// completes and `ready` rises.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   When the macro is defined, a read of the address being written in the
//   same cycle returns data_in (write-first). When it is undefined, such a
//   read returns the pre-write stored value.
//
// Parameters:
//   DATA_WIDTH - width of each entry and data port
//   ADDR_WIDTH - address width; DEPTH = 2**ADDR_WIDTH entries
//   ZERO_REG   - 1: entry 0 reads as zero and ignores writes
//
// Ports:
//   clk           - clock; all state updates on the rising edge
//   reset         - synchronous, active-high reset; restarts the clear
//   read1_address - read port 1 address
//   read2_address - read port 2 address
//   data1_out     - read port 1 data (combinational)
//   data2_out     - read port 2 data (combinational)
//   write_enable  - commit data_in to write_address at the next edge
//   write_address - write port address
//   data_in       - write data
//   ready         - high once the clear sequence has completed
module register_file_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read1_address,
    input  logic [ADDR_WIDTH-1:0] read2_address,
    output logic [DATA_WIDTH-1:0] data1_out,
    output logic [DATA_WIDTH-1:0] data2_out,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   clear_count_r;
    logic                    ready_r;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
    logic [DATA_WIDTH-1:0]   data1_s;
    logic [DATA_WIDTH-1:0]   data2_s;
    logic                    zero_hit1_s;
    logic                    zero_hit2_s;
    logic                    zero_wr_s;

    // Entry 0 is hardwired only when ZERO_REG is set.
    assign zero_hit1_s = (ZERO_REG != 0) && (read1_address == ADDR_ZERO);
    assign zero_hit2_s = (ZERO_REG != 0) && (read2_address == ADDR_ZERO);
    assign zero_wr_s   = (ZERO_REG != 0) && (write_address == ADDR_ZERO);

    // Clear sequencer, write port, and registered ready flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_CLEAR;
            clear_count_r <= ADDR_ZERO;
            ready_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    mem_r[clear_count_r] <= DATA_ZERO;
                    if (clear_count_r == ADDR_LAST) begin
                        // The last entry is cleared; hold the count rather than wrap.
                        state_r       <= ST_RUN;
                        ready_r       <= 1'b1;
                        clear_count_r <= clear_count_r;
                    end else begin
                        state_r       <= ST_CLEAR;
                        ready_r       <= 1'b0;
                        clear_count_r <= clear_count_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                ST_RUN: begin
                    if (write_enable && !zero_wr_s) begin
                        mem_r[write_address] <= data_in;
                    end else begin
                        mem_r[write_address] <= mem_r[write_address];
                    end
                end
                default: begin
                    state_r       <= ST_CLEAR;
                    clear_count_r <= ADDR_ZERO;
                    ready_r       <= 1'b0;
                end
            endcase
        end
    end

    // Read port 1: forced to zero while clearing or when hitting a hardwired entry 0.
    always_comb begin
        data1_s = DATA_ZERO;
        if (state_r == ST_RUN) begin
            if (zero_hit1_s) begin
                data1_s = DATA_ZERO;
            end
`ifdef REGFILE_BYPASS_EN
            else if (write_enable && (write_address == read1_address)) begin
                data1_s = data_in;
            end
`endif
            else begin
                data1_s = mem_r[read1_address];
            end
        end else begin
            data1_s = DATA_ZERO;
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        data2_s = DATA_ZERO;
        if (state_r == ST_RUN) begin
            if (zero_hit2_s) begin
                data2_s = DATA_ZERO;
            end
`ifdef REGFILE_BYPASS_EN
            else if (write_enable && (write_address == read2_address)) begin
                data2_s = data_in;
            end
`endif
            else begin
                data2_s = mem_r[read2_address];
            end
        end else begin
            data2_s = DATA_ZERO;
        end
    end

    assign data1_out = data1_s;
    assign data2_out = data2_s;
    assign ready     = ready_r;

endmodule
